// File: rtl/spin_sequencer.sv
// Frame-code sequencer for the seven-segment spinning-disk animation.
// Steps bin through FIRST_CODE..LAST_CODE at a programmable rate, with pause, single-step and wrap pulse.
module spin_sequencer #(
    parameter int unsigned DIV_W      = 24,
    parameter logic [2:0]  FIRST_CODE = 3'd1,
    parameter logic [2:0]  LAST_CODE  = 3'd5,
    parameter logic [2:0]  BLANK_CODE = 3'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pause,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             step_req,
    output logic [2:0]       bin,
    output logic             dp,
    output logic             rev_pulse,
    output logic             running
);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [2:0]       bin_q, bin_d;
    logic             dp_q, dp_d;
    logic             rev_q, rev_d;
    logic             step_prev_q;

    logic       step_rise;
    logic       advance;
    logic       wrap;
    logic [2:0] next_code;

    assign step_rise = step_req & ~step_prev_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            bin_q       <= BLANK_CODE;
            dp_q        <= 1'b0;
            rev_q       <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            bin_q       <= bin_d;
            dp_q        <= dp_d;
            rev_q       <= rev_d;
            step_prev_q <= step_req;
        end
    end

    // Next-state logic; en=0 overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en) state_d = pause ? StHold : StRun;
            StRun: begin
                if (!en)       state_d = StIdle;
                else if (pause) state_d = StHold;
            end
            StHold: begin
                if (!en)        state_d = StIdle;
                else if (!pause) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (dir) begin
            wrap      = (bin_q == FIRST_CODE);
            next_code = wrap ? LAST_CODE : bin_q - 3'd1;
        end else begin
            wrap      = (bin_q == LAST_CODE);
            next_code = wrap ? FIRST_CODE : bin_q + 3'd1;
        end
    end

    // Output / datapath next values
    always_comb begin
        presc_d = presc_q;
        bin_d   = bin_q;
        dp_d    = dp_q;
        rev_d   = 1'b0;
        advance = 1'b0;
        running = (state_q == StRun);
        if (!en) begin
            presc_d = '0;
            bin_d   = BLANK_CODE;
            dp_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    presc_d = '0;
                    bin_d   = dir ? LAST_CODE : FIRST_CODE;
                    dp_d    = 1'b0;
                end
                StRun: begin
                    // >= so a div lowered below the current count fires at once
                    if (presc_q >= div) begin
                        advance = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
                StHold: begin
                    advance = step_rise;
                    if (!pause) presc_d = '0;
                end
                default: begin
                    presc_d = '0;
                    bin_d   = BLANK_CODE;
                    dp_d    = 1'b0;
                end
            endcase
            if (advance) begin
                bin_d = next_code;
                if (wrap) begin
                    rev_d = 1'b1;
                    dp_d  = ~dp_q;
                end
            end
        end
    end

    assign bin       = bin_q;
    assign dp        = dp_q;
    assign rev_pulse = rev_q;

endmodule

// File: tb/tb_spin_sequencer.sv
// Directed bench for spin_sequencer: rate, direction, pause/step, div shrink, disable and async reset.
module tb_spin_sequencer;

    localparam int unsigned DIV_W = 24;

    logic             clk;
    logic             reset;
    logic             en;
    logic             pause;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic             step_req;
    logic [2:0]       bin;
    logic             dp;
    logic             rev_pulse;
    logic             running;

    int n_checks = 0;
    int n_errs   = 0;

    spin_sequencer #(
        .DIV_W      (DIV_W),
        .FIRST_CODE (3'd1),
        .LAST_CODE  (3'd5),
        .BLANK_CODE (3'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .pause     (pause),
        .dir       (dir),
        .div       (div),
        .step_req  (step_req),
        .bin       (bin),
        .dp        (dp),
        .rev_pulse (rev_pulse),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int exp_dn [6];
        exp_dn = '{5, 4, 3, 2, 1, 5};

        reset    = 1'b1;
        en       = 1'b0;
        pause    = 1'b0;
        dir      = 1'b0;
        div      = '0;
        step_req = 1'b0;
        #3;
        check_eq("rst_bin", 32'(bin), 0);
        check_eq("rst_dp", 32'(dp), 0);
        check_eq("rst_rev", 32'(rev_pulse), 0);
        check_eq("rst_running", 32'(running), 0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("idle_bin", 32'(bin), 0);

        // Rate: div=3 holds each code 4 cycles
        div = 3;
        en  = 1'b1;
        tick();
        check_eq("run_running", 32'(running), 1);
        for (int i = 0; i < 24; i++) begin
            check_eq($sformatf("rate_bin%0d", i), 32'(bin), 32'(1 + (i / 4) % 5));
            check_eq($sformatf("rate_rev%0d", i), 32'(rev_pulse), 32'(i == 20));
            check_eq($sformatf("rate_dp%0d", i), 32'(dp), 32'(i >= 20));
            tick();
        end

        // Disable then re-enable
        en = 1'b0;
        tick();
        check_eq("dis_bin", 32'(bin), 0);
        check_eq("dis_dp", 32'(dp), 0);
        check_eq("dis_running", 32'(running), 0);
        en = 1'b1;
        tick();
        check_eq("reen_bin", 32'(bin), 1);
        check_eq("reen_dp", 32'(dp), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq($sformatf("reen_per%0d", i), 32'(bin), (i < 4) ? 32'd1 : 32'd2);
        end

        // Direction: down, div=0
        en = 1'b0;
        tick();
        dir = 1'b1;
        div = 0;
        en  = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("dn_bin%0d", i), 32'(bin), 32'(exp_dn[i]));
            check_eq($sformatf("dn_rev%0d", i), 32'(rev_pulse), 32'(i == 5));
            tick();
        end
        check_eq("dn_bin_after", 32'(bin), 4);
        check_eq("dn_dp", 32'(dp), 1);
        dir = 1'b0;
        tick();
        check_eq("flip_bin5", 32'(bin), 5);
        tick();
        check_eq("flip_bin1", 32'(bin), 1);
        check_eq("flip_rev", 32'(rev_pulse), 1);
        check_eq("flip_dp", 32'(dp), 0);

        // Pause and single-step
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        tick();
        check_eq("pre_pause_bin", 32'(bin), 2);
        pause = 1'b1;
        tick();
        check_eq("pause_bin", 32'(bin), 3);
        check_eq("pause_running", 32'(running), 0);
        bad = 0;
        repeat (100) begin
            tick();
            if (bin !== 3'd3) bad++;
        end
        check_eq("hold_100", 32'(bad), 0);
        step_req = 1'b1;
        tick();
        check_eq("step1_bin", 32'(bin), 4);
        check_eq("step1_rev", 32'(rev_pulse), 0);
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        check_eq("step2_bin", 32'(bin), 5);
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        check_eq("step3_bin", 32'(bin), 1);
        check_eq("step3_rev", 32'(rev_pulse), 1);
        check_eq("step3_dp", 32'(dp), 1);
        tick();
        check_eq("step_hold_rev", 32'(rev_pulse), 0);
        repeat (4) tick();
        check_eq("step_held_bin", 32'(bin), 1);
        step_req = 1'b0;
        pause    = 1'b0;
        tick();
        check_eq("resume_running", 32'(running), 1);
        check_eq("resume_bin", 32'(bin), 1);
        tick();
        check_eq("resume_adv", 32'(bin), 2);

        // div shrink mid-count
        en = 1'b0;
        tick();
        div = 1000;
        en  = 1'b1;
        tick();
        repeat (500) tick();
        check_eq("shrink_pre", 32'(bin), 1);
        div = 10;
        tick();
        check_eq("shrink_adv", 32'(bin), 2);
        for (int p = 0; p < 2; p++) begin
            bad = 0;
            repeat (10) begin
                tick();
                if (bin !== 3'(2 + p)) bad++;
            end
            check_eq($sformatf("shrink_hold%0d", p), 32'(bad), 0);
            tick();
            check_eq($sformatf("shrink_next%0d", p), 32'(bin), 32'(3 + p));
        end

        // Async reset mid-run, away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        check_eq("areset_bin", 32'(bin), 0);
        check_eq("areset_dp", 32'(dp), 0);
        check_eq("areset_running", 32'(running), 0);
        check_eq("areset_rev", 32'(rev_pulse), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
